accel_dot_sched: RTL and testbench

- Round-robin scheduler that shares one accel_dot engine between NUM_REQ requesters.
- Each requester sends an IN_LEN-word input vector on its own AXI4-Stream slave port.
- The block grants one requester, forwards its vector to the engine, then routes the engine's OUT_LEN-word result back to that requester's output stream.
- Sits between the DMA/stream fabric and a single accel_dot instance. The engine must share the same clk/rst.

---
 rtl/accel_dot_pkg.sv | 19 +
 rtl/accel_dot_sched_rr_arbiter.sv | 28 ++
 rtl/accel_dot_sched.sv | 115 +++++++++++
 tb/tb_accel_dot_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_dot_pkg.sv
// Shared types and default sizes for the accel_dot engine and its request scheduler.
package accel_dot_pkg;

  localparam int DATA_W  = 32;
  localparam int IN_LEN  = 3;
  localparam int OUT_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV
  } sched_state_t;

  // Counter width able to hold the longest of the two vector lengths.
  function automatic int cnt_width(input int in_len, input int out_len);
    return $clog2(((in_len > out_len) ? in_len : out_len) + 1);
  endfunction

endpackage

// File: rtl/accel_dot_sched_rr_arbiter.sv
// Round-robin pick: first asserted request strictly after the last served index, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);
  import accel_dot_pkg::*;

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the closest candidate after 'last' wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/accel_dot_sched.sv
// Shares one accel_dot engine between NUM_REQ AXI4-Stream requesters, one vector in flight at a time.
module accel_dot_sched #(
  parameter  int DATA_W  = accel_dot_pkg::DATA_W,
  parameter  int NUM_REQ = 2,
  parameter  int IN_LEN  = accel_dot_pkg::IN_LEN,
  parameter  int OUT_LEN = accel_dot_pkg::OUT_LEN,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_IN_AXIS_TDATA,
  input  logic [NUM_REQ-1:0]        REQ_IN_AXIS_TLAST,
  input  logic [NUM_REQ-1:0]        REQ_IN_AXIS_TVALID,
  output logic [NUM_REQ-1:0]        REQ_IN_AXIS_TREADY,
  output logic [NUM_REQ*DATA_W-1:0] REQ_OUT_AXIS_TDATA,
  output logic [NUM_REQ-1:0]        REQ_OUT_AXIS_TLAST,
  output logic [NUM_REQ-1:0]        REQ_OUT_AXIS_TVALID,
  input  logic [NUM_REQ-1:0]        REQ_OUT_AXIS_TREADY,
  output logic [DATA_W-1:0]         ENG_IN_AXIS_TDATA,
  output logic                      ENG_IN_AXIS_TLAST,
  output logic                      ENG_IN_AXIS_TVALID,
  input  logic                      ENG_IN_AXIS_TREADY,
  input  logic [DATA_W-1:0]         ENG_OUT_AXIS_TDATA,
  input  logic                      ENG_OUT_AXIS_TLAST,
  input  logic                      ENG_OUT_AXIS_TVALID,
  output logic                      ENG_OUT_AXIS_TREADY,
  output logic [GW-1:0]             grant,
  output logic                      busy,
  output logic                      frame_err
);
  import accel_dot_pkg::*;

  localparam int CW = cnt_width(IN_LEN, OUT_LEN);

  sched_state_t  state, state_nxt;
  logic [GW-1:0] grant_q, last_q, arb_grant;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          arb_any, frame_err_q;
  logic          in_hs, out_hs, in_last, out_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (REQ_IN_AXIS_TVALID),
    .last    (last_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign in_last  = (in_cnt == CW'(IN_LEN - 1));
  assign out_last = (out_cnt == CW'(OUT_LEN - 1));
  assign in_hs    = (state == SEND) && REQ_IN_AXIS_TVALID[grant_q] && ENG_IN_AXIS_TREADY;
  assign out_hs   = (state == RECV) && ENG_OUT_AXIS_TVALID && REQ_OUT_AXIS_TREADY[grant_q];

  // Data buses are steered unconditionally; only the valid/ready/last strobes are gated by state.
  assign ENG_IN_AXIS_TDATA  = REQ_IN_AXIS_TDATA[int'(grant_q)*DATA_W +: DATA_W];
  assign REQ_OUT_AXIS_TDATA = {NUM_REQ{ENG_OUT_AXIS_TDATA}};
  assign grant              = grant_q;
  assign busy               = (state != IDLE);
  assign frame_err          = frame_err_q;

  always_comb begin
    state_nxt           = state;
    REQ_IN_AXIS_TREADY  = '0;
    REQ_OUT_AXIS_TVALID = '0;
    REQ_OUT_AXIS_TLAST  = '0;
    ENG_IN_AXIS_TVALID  = 1'b0;
    ENG_IN_AXIS_TLAST   = 1'b0;
    ENG_OUT_AXIS_TREADY = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) state_nxt = SEND;
      end
      SEND: begin
        ENG_IN_AXIS_TVALID          = REQ_IN_AXIS_TVALID[grant_q];
        ENG_IN_AXIS_TLAST           = in_last;
        REQ_IN_AXIS_TREADY[grant_q] = ENG_IN_AXIS_TREADY;
        if (in_hs && in_last) state_nxt = RECV;
      end
      RECV: begin
        REQ_OUT_AXIS_TVALID[grant_q] = ENG_OUT_AXIS_TVALID;
        REQ_OUT_AXIS_TLAST[grant_q]  = out_last;
        ENG_OUT_AXIS_TREADY          = REQ_OUT_AXIS_TREADY[grant_q];
        if (out_hs && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The round-robin pointer only advances once a result has fully drained back to its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      in_cnt      <= '0;
      out_cnt     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_any) begin
        grant_q <= arb_grant;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (in_hs) begin
        in_cnt <= in_cnt + CW'(1);
        if (REQ_IN_AXIS_TLAST[grant_q] && !in_last) frame_err_q <= 1'b1;
      end
      if (out_hs) begin
        out_cnt <= out_cnt + CW'(1);
        if (out_last) last_q <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_accel_dot_sched.sv
// Scoreboard bench for accel_dot_sched with a behavioural dot-product engine (weights 1..12, row-major 3x4).
module tb_accel_dot_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] REQ_IN_AXIS_TDATA;
  logic [1:0]  REQ_IN_AXIS_TLAST, REQ_IN_AXIS_TVALID, REQ_IN_AXIS_TREADY;
  logic [63:0] REQ_OUT_AXIS_TDATA;
  logic [1:0]  REQ_OUT_AXIS_TLAST, REQ_OUT_AXIS_TVALID, REQ_OUT_AXIS_TREADY;
  logic [31:0] ENG_IN_AXIS_TDATA, ENG_OUT_AXIS_TDATA;
  logic        ENG_IN_AXIS_TLAST, ENG_IN_AXIS_TVALID, ENG_IN_AXIS_TREADY;
  logic        ENG_OUT_AXIS_TLAST, ENG_OUT_AXIS_TVALID, ENG_OUT_AXIS_TREADY;
  logic [0:0]  grant;
  logic        busy, frame_err;

  accel_dot_sched #(.DATA_W(32), .NUM_REQ(2), .IN_LEN(3), .OUT_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .REQ_IN_AXIS_TDATA(REQ_IN_AXIS_TDATA), .REQ_IN_AXIS_TLAST(REQ_IN_AXIS_TLAST),
    .REQ_IN_AXIS_TVALID(REQ_IN_AXIS_TVALID), .REQ_IN_AXIS_TREADY(REQ_IN_AXIS_TREADY),
    .REQ_OUT_AXIS_TDATA(REQ_OUT_AXIS_TDATA), .REQ_OUT_AXIS_TLAST(REQ_OUT_AXIS_TLAST),
    .REQ_OUT_AXIS_TVALID(REQ_OUT_AXIS_TVALID), .REQ_OUT_AXIS_TREADY(REQ_OUT_AXIS_TREADY),
    .ENG_IN_AXIS_TDATA(ENG_IN_AXIS_TDATA), .ENG_IN_AXIS_TLAST(ENG_IN_AXIS_TLAST),
    .ENG_IN_AXIS_TVALID(ENG_IN_AXIS_TVALID), .ENG_IN_AXIS_TREADY(ENG_IN_AXIS_TREADY),
    .ENG_OUT_AXIS_TDATA(ENG_OUT_AXIS_TDATA), .ENG_OUT_AXIS_TLAST(ENG_OUT_AXIS_TLAST),
    .ENG_OUT_AXIS_TVALID(ENG_OUT_AXIS_TVALID), .ENG_OUT_AXIS_TREADY(ENG_OUT_AXIS_TREADY),
    .grant(grant), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] in_data [2];
  logic        in_valid [2];
  logic        in_last [2];
  logic        out_ready;
  int          out_mode = 0;
  assign REQ_IN_AXIS_TDATA   = {in_data[1], in_data[0]};
  assign REQ_IN_AXIS_TVALID  = {in_valid[1], in_valid[0]};
  assign REQ_IN_AXIS_TLAST   = {in_last[1], in_last[0]};
  assign REQ_OUT_AXIS_TREADY = {out_ready, out_ready};

  logic [31:0] vin [2][3];
  real         vexp [2][4];
  real         exp_q [2][$];
  int          exp_grant_q [$];
  int          mon_idx [2];
  logic        stray_ready = 1'b0;
  logic        mirror_bad  = 1'b0;

  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real x);
    logic [63:0] d;
    logic [30:0] m;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    m = {8'(int'(d[62:52]) - 1023 + 127), d[51:29]} + 31'(d[28]);
    return {d[63], m};
  endfunction

  function automatic logic [31:0] dotj(input logic [31:0] x0, x1, x2, input int j);
    return real2sp(sp2real(x0) * (j + 1) + sp2real(x1) * (j + 5) + sp2real(x2) * (j + 9));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic checkReal(input string name, input real act, input real expv);
    real diff;
    diff = act - expv;
    if (diff < 0.0) diff = -diff;
    n_checks++;
    if (diff <= 1.0e-6) n_pass++;
    else $display("[TB] FAIL %s: got %f, expected %f", name, act, expv);
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    $display("[TB] FAIL %s: got timeout, expected completion", name);
  endtask

  // Behavioural engine: handshakes sampled on the falling edge, state updated on the rising edge.
  logic [31:0] eng_buf [3];
  logic [31:0] eng_res [4];
  logic        eng_out;
  int          eng_icnt, eng_ocnt;
  logic        s_in_hs, s_out_hs;
  logic [31:0] s_in_d;
  assign ENG_IN_AXIS_TREADY  = !eng_out;
  assign ENG_OUT_AXIS_TVALID = eng_out;
  assign ENG_OUT_AXIS_TDATA  = eng_res[eng_ocnt];
  assign ENG_OUT_AXIS_TLAST  = eng_out && (eng_ocnt == 3);

  always @(negedge clk) begin
    s_in_hs  = ENG_IN_AXIS_TVALID && ENG_IN_AXIS_TREADY;
    s_out_hs = ENG_OUT_AXIS_TVALID && ENG_OUT_AXIS_TREADY;
    s_in_d   = ENG_IN_AXIS_TDATA;
    if (!rst && s_in_hs) checkOutput("eng_in_tlast", 32'(ENG_IN_AXIS_TLAST), 32'(eng_icnt == 2));
  end

  always @(posedge clk) begin
    if (rst) begin
      eng_out  <= 1'b0;
      eng_icnt <= 0;
      eng_ocnt <= 0;
    end else if (!eng_out && s_in_hs) begin
      eng_buf[eng_icnt] <= s_in_d;
      if (eng_icnt == 2) begin
        for (int j = 0; j < 4; j++) eng_res[j] <= dotj(eng_buf[0], eng_buf[1], s_in_d, j);
        eng_out  <= 1'b1;
        eng_ocnt <= 0;
        eng_icnt <= 0;
      end else begin
        eng_icnt <= eng_icnt + 1;
      end
    end else if (eng_out && s_out_hs) begin
      if (eng_ocnt == 3) eng_out <= 1'b0;
      else eng_ocnt <= eng_ocnt + 1;
    end
  end

  // Output-side ready: 0 = always ready, 1 = repeating 1,0,0,1, 2 = stalled.
  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on every result handshake and watches for stray strobes.
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        if (REQ_OUT_AXIS_TVALID[r] && REQ_OUT_AXIS_TREADY[r]) begin
          if (exp_q[r].size() == 0) begin
            checkOutput($sformatf("unexpected_word_r%0d", r), REQ_OUT_AXIS_TDATA[r*32 +: 32], 32'hxxxxxxxx);
          end else begin
            checkReal($sformatf("data_r%0d_w%0d", r, mon_idx[r]),
                      sp2real(REQ_OUT_AXIS_TDATA[r*32 +: 32]), exp_q[r].pop_front());
            checkOutput($sformatf("tlast_r%0d_w%0d", r, mon_idx[r]),
                        32'(REQ_OUT_AXIS_TLAST[r]), 32'(mon_idx[r] == 3));
            if (mon_idx[r] == 3) begin
              mon_idx[r] = 0;
              if (exp_grant_q.size() == 0) begin
                checkOutput("grant_order", 32'(r), 32'hxxxxxxxx);
              end else begin
                int g;
                g = exp_grant_q.pop_front();
                checkOutput("grant_order", 32'(r), 32'(g));
                checkOutput("grant_port", 32'(grant), 32'(g));
              end
            end else begin
              mon_idx[r]++;
            end
          end
        end
      end
      if ((REQ_IN_AXIS_TREADY & ~(2'b01 << grant)) != 2'b00) stray_ready = 1'b1;
      if (!busy && REQ_IN_AXIS_TREADY != 2'b00) stray_ready = 1'b1;
      if (REQ_OUT_AXIS_TVALID[grant] && (ENG_OUT_AXIS_TREADY != REQ_OUT_AXIS_TREADY[grant])) mirror_bad = 1'b1;
      if (ENG_OUT_AXIS_TREADY && !REQ_OUT_AXIS_TREADY[grant]) mirror_bad = 1'b1;
    end
  end

  task automatic applyStimulus(input int r, input int vec, input logic [2:0] tlast_mask, input int gap_beat);
    int n;
    for (int k = 0; k < 4; k++) exp_q[r].push_back(vexp[vec][k]);
    for (int i = 0; i < 3; i++) begin
      if (i == gap_beat) begin
        in_valid[r] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      in_data[r]  = vin[vec][i];
      in_last[r]  = tlast_mask[i];
      in_valid[r] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!REQ_IN_AXIS_TREADY[r] && n < 300);
      if (!REQ_IN_AXIS_TREADY[r]) begin
        reportFail($sformatf("in_handshake_r%0d", r));
        in_valid[r] = 1'b0;
        in_last[r]  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid[r] = 1'b0;
    in_last[r]  = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_grant_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_grant_q.size() != 0) begin
      reportFail(name);
      exp_q[0].delete();
      exp_q[1].delete();
      exp_grant_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int n;
    vin[0][0] = 32'h3DCCCCCD; vin[0][1] = 32'h3E4CCCCD; vin[0][2] = 32'h3E99999A;
    vin[1][0] = 32'h3F800000; vin[1][1] = 32'h00000000; vin[1][2] = 32'h00000000;
    vexp[0][0] = 3.8000002; vexp[0][1] = 4.4; vexp[0][2] = 5.0; vexp[0][3] = 5.6000004;
    vexp[1][0] = 1.0;       vexp[1][1] = 2.0; vexp[1][2] = 3.0; vexp[1][3] = 4.0;
    for (int r = 0; r < 2; r++) begin
      in_data[r] = '0; in_valid[r] = 1'b0; in_last[r] = 1'b0; mon_idx[r] = 0;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_req_in_tready", 32'(REQ_IN_AXIS_TREADY), 32'd0);
    checkOutput("reset_req_out_tvalid", 32'(REQ_OUT_AXIS_TVALID), 32'd0);
    checkOutput("reset_eng_in_tvalid", 32'(ENG_IN_AXIS_TVALID), 32'd0);
    checkOutput("reset_eng_out_tready", 32'(ENG_OUT_AXIS_TREADY), 32'd0);

    $display("[TB] both requesters at once from reset: r0 then r1");
    @(posedge clk); #1;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    fork
      applyStimulus(0, 0, 3'b100, -1);
      applyStimulus(1, 1, 3'b100, -1);
    join
    waitDrain("drain_both");

    $display("[TB] single requester 0");
    exp_grant_q.push_back(0);
    applyStimulus(0, 0, 3'b100, -1);
    waitDrain("drain_single");
    checkOutput("single_grant", 32'(grant), 32'd0);
    checkOutput("single_frame_err", 32'(frame_err), 32'd0);

    $display("[TB] back-to-back repeat after r0: r1 then r0");
    exp_grant_q.push_back(1); exp_grant_q.push_back(0);
    fork
      applyStimulus(0, 0, 3'b100, -1);
      applyStimulus(1, 1, 3'b100, -1);
    join
    waitDrain("drain_repeat");

    $display("[TB] output backpressure on r1");
    out_mode = 1;
    mirror_bad = 1'b0;
    exp_grant_q.push_back(1);
    applyStimulus(1, 1, 3'b100, -1);
    waitDrain("drain_backpressure");
    checkOutput("eng_out_tready_mirror", 32'(mirror_bad), 32'd0);
    out_mode = 0;

    $display("[TB] r0 drops valid mid-vector while r1 waits");
    stray_ready = 1'b0;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    fork
      applyStimulus(0, 0, 3'b100, 1);
      applyStimulus(1, 1, 3'b100, -1);
    join
    waitDrain("drain_gap");
    checkOutput("no_stray_tready", 32'(stray_ready), 32'd0);

    $display("[TB] early TLAST on word 1");
    exp_grant_q.push_back(1);
    applyStimulus(1, 1, 3'b110, -1);
    waitDrain("drain_frame");
    checkOutput("frame_err_set", 32'(frame_err), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("frame_err_sticky", 32'(frame_err), 32'd1);

    $display("[TB] reset during RECV");
    out_mode = 2;
    applyStimulus(0, 0, 3'b100, -1);
    n = 0;
    while (!REQ_OUT_AXIS_TVALID[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!REQ_OUT_AXIS_TVALID[0]) reportFail("reach_recv");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q[0].delete(); exp_q[1].delete(); exp_grant_q.delete();
    mon_idx[0] = 0; mon_idx[1] = 0;
    out_mode = 0;
    @(negedge clk);
    checkOutput("rst_recv_busy", 32'(busy), 32'd0);
    checkOutput("rst_recv_req_out_tvalid", 32'(REQ_OUT_AXIS_TVALID), 32'd0);
    checkOutput("rst_recv_eng_in_tvalid", 32'(ENG_IN_AXIS_TVALID), 32'd0);
    checkOutput("rst_recv_req_in_tready", 32'(REQ_IN_AXIS_TREADY), 32'd0);
    checkOutput("rst_recv_eng_out_tready", 32'(ENG_OUT_AXIS_TREADY), 32'd0);
    checkOutput("rst_recv_frame_err", 32'(frame_err), 32'd0);

    $display("[TB] vector after mid-operation reset");
    exp_grant_q.push_back(1);
    applyStimulus(1, 1, 3'b100, -1);
    waitDrain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
